// File: rtl/node_share_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared compute node.
interface node_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 16
);
    logic [N_REQ-1:0]   REQ;
    logic [N_REQ*W-1:0] IN0_BUS;
    logic [N_REQ*W-1:0] IN1_BUS;
    logic [N_REQ-1:0]   GNT;
    logic [N_REQ-1:0]   DONE;
    logic               ERR;
    logic [W-1:0]       RES;
    logic               BUSY;
    logic               NODE_ST;
    logic [W-1:0]       NODE_IN0;
    logic [W-1:0]       NODE_IN1;
    logic               NODE_RD;
    logic [W-1:0]       NODE_RES;

    // Arbiter side
    modport slave (
        input  REQ, IN0_BUS, IN1_BUS, NODE_RD, NODE_RES,
        output GNT, DONE, ERR, RES, BUSY, NODE_ST, NODE_IN0, NODE_IN1
    );

    // Client and node side
    modport master (
        output REQ, IN0_BUS, IN1_BUS, NODE_RD, NODE_RES,
        input  GNT, DONE, ERR, RES, BUSY, NODE_ST, NODE_IN0, NODE_IN1
    );
endinterface

// File: rtl/node_share_arbiter.sv
// Round-robin sharing of one two-operand compute node among N_REQ requesters,
// with a watchdog that aborts a node that never raises ready.
//
// state | meaning
// IDLE  | no service; pick next requester from ptr, latch its operands
// ISSUE | one-cycle start pulse to the node, watchdog cleared
// WAIT  | wait for node ready or watchdog expiry
// RESP  | one-cycle DONE (and ERR on abort) to the granted requester
module node_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    node_share_arbiter_if.slave   bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nx;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    sel_idx;
    logic             sel_vld;
    logic             abort;
    logic [CW-1:0]    wdog;
    logic [N_REQ-1:0] gnt_q;
    logic [W-1:0]     res_q;
    logic [W-1:0]     in0_q;
    logic [W-1:0]     in1_q;
    int               idx;

    // First set REQ bit scanning ptr, ptr+1, ... with wrap at N_REQ
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!sel_vld && bus.REQ[PW'(idx)]) begin
                sel_vld = 1'b1;
                sel_idx = PW'(idx);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.DONE     = '0;
        bus.ERR      = 1'b0;
        bus.NODE_ST  = 1'b0;
        bus.BUSY     = 1'b1;
        case (state)
            IDLE: begin
                bus.BUSY = 1'b0;
                if (sel_vld) state_nx = ISSUE;
            end
            ISSUE: begin
                bus.NODE_ST = 1'b1;
                state_nx    = WAIT;
            end
            WAIT: begin
                if (bus.NODE_RD || wdog == CW'(TIMEOUT)) state_nx = RESP;
            end
            RESP: begin
                bus.DONE = gnt_q;
                bus.ERR  = abort;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr     <= '0;
            gnt_idx <= '0;
            gnt_q   <= '0;
            abort   <= 1'b0;
            wdog    <= '0;
            res_q   <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        gnt_idx <= sel_idx;
                        gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        in0_q   <= bus.IN0_BUS[sel_idx*W +: W];
                        in1_q   <= bus.IN1_BUS[sel_idx*W +: W];
                    end
                end
                ISSUE: wdog <= '0;
                WAIT: begin
                    // Ready beats the watchdog when both land in the same cycle
                    if (bus.NODE_RD) begin
                        res_q <= bus.NODE_RES;
                    end else if (wdog == CW'(TIMEOUT)) begin
                        res_q <= '0;
                        abort <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    gnt_q <= '0;
                    abort <= 1'b0;
                    ptr   <= (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.GNT      = gnt_q;
    assign bus.RES      = res_q;
    assign bus.NODE_IN0 = in0_q;
    assign bus.NODE_IN1 = in1_q;
endmodule

// File: tb/tb_node_share_arbiter.sv
// Bench for node_share_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-timeline model.
module tb_node_share_arbiter;
    localparam int N_REQ   = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 10;
    localparam int CW      = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    node_share_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

    node_share_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        int          d;
        logic [3:0]  gnt;
        int          lat;
        logic [15:0] res;
        logic        err;
    } vec_t;

    vec_t        vt[10];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [W-1:0] op0[N_REQ];
    logic [W-1:0] op1[N_REQ];

    // Node model: ready pulses node_d cycles after the start pulse, 0 = never
    int node_d   = 0;
    int node_dl  = 0;
    int node_cnt = 0;
    bit node_arm = 1'b0;
    always @(negedge CLK) begin
        bus.NODE_RD  = 1'b0;
        bus.NODE_RES = W'($urandom);
        if (RST) begin
            node_arm = 1'b0;
        end else if (bus.NODE_ST) begin
            node_arm = 1'b1;
            node_cnt = 0;
            node_dl  = node_d;
        end else if (node_arm) begin
            node_cnt++;
            if (node_dl != 0 && node_cnt == node_dl) begin
                bus.NODE_RD  = 1'b1;
                bus.NODE_RES = bus.NODE_IN0 + bus.NODE_IN1;
                node_arm     = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] obs();
        return {5'b0, bus.GNT, bus.DONE, bus.ERR, bus.NODE_ST, bus.BUSY,
                bus.RES, bus.NODE_IN0, bus.NODE_IN1};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N_REQ; i++) begin
            bus.IN0_BUS[i*W +: W] = op0[i];
            bus.IN1_BUS[i*W +: W] = op1[i];
        end
    endtask

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < N_REQ; i++) begin
            op0[i] = a;
            op1[i] = b;
        end
        drive_ops();
    endtask

    task automatic scramble();
        for (int i = 0; i < N_REQ; i++) begin
            op0[i] = W'($urandom);
            op1[i] = W'($urandom);
        end
        drive_ops();
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        bus.REQ = '0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input int r);
        int lat;
        lat    = 0;
        node_d = v.d;
        set_ops(v.a, v.b);
        bus.REQ = v.req;
        tick();
        check($sformatf("row%0d_gnt", r), bus.GNT, v.gnt);
        check($sformatf("row%0d_st", r), bus.NODE_ST, 1);
        bus.REQ = '0;
        while (bus.DONE == '0 && lat < 40) begin
            scramble();
            tick();
            lat++;
        end
        check($sformatf("row%0d_lat", r), lat, v.lat);
        check($sformatf("row%0d_done", r), bus.DONE, v.gnt);
        check($sformatf("row%0d_err", r), bus.ERR, v.err);
        check($sformatf("row%0d_res", r), bus.RES, v.res);
        check($sformatf("row%0d_in0", r), bus.NODE_IN0, v.a);
        tick();
        check($sformatf("row%0d_idle", r), {bus.BUSY, bus.DONE, bus.ERR}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          t;
        int          d;
        int          m_ptr, m_g, m_s, m_done, m_free;
        bit          m_act;
        logic        m_e;
        logic [W-1:0] m_r, m_res, m_nin0, m_nin1;
        logic [3:0]  eg, ed, rq;
        logic        ee, est, eb;

        // ptr carries from row to row: 0 after reset
        vt[0] = '{4'b0001, 16'h0003, 16'h0005, 4,  4'b0001, 5,  16'h0008, 1'b0};
        vt[1] = '{4'b0001, 16'h000A, 16'h0014, 1,  4'b0001, 2,  16'h001E, 1'b0};
        vt[2] = '{4'b1111, 16'h0001, 16'h0001, 2,  4'b0010, 3,  16'h0002, 1'b0};
        vt[3] = '{4'b1011, 16'h0100, 16'h0023, 3,  4'b1000, 4,  16'h0123, 1'b0};
        vt[4] = '{4'b1010, 16'h0007, 16'h0008, 5,  4'b0010, 6,  16'h000F, 1'b0};
        vt[5] = '{4'b0001, 16'h8000, 16'h8000, 2,  4'b0001, 3,  16'h0000, 1'b0};
        vt[6] = '{4'b0001, 16'h1111, 16'h2222, 11, 4'b0001, 12, 16'h3333, 1'b0};
        vt[7] = '{4'b0100, 16'hAAAA, 16'h5555, 0,  4'b0100, 12, 16'h0000, 1'b1};
        vt[8] = '{4'b1001, 16'h0002, 16'h0003, 1,  4'b1000, 2,  16'h0005, 1'b0};
        vt[9] = '{4'b0110, 16'hFFFF, 16'h0002, 7,  4'b0010, 8,  16'h0001, 1'b0};

        bus.REQ = '0;
        set_ops('0, '0);
        do_reset();
        check("reset_state", obs(), 0);

        for (int r = 0; r < 10; r++) run_row(vt[r], r);

        // Continuous load on 0 and 2 must alternate
        do_reset();
        node_d  = 1;
        set_ops(16'h0011, 16'h0022);
        bus.REQ = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!bus.NODE_ST && t < 20) begin
                tick();
                t++;
            end
            check($sformatf("fair_gnt%0d", k), bus.GNT, (k % 2 == 1) ? 4'b0100 : 4'b0001);
            tick();
        end
        bus.REQ = '0;
        t = 0;
        while (bus.BUSY && t < 20) begin
            tick();
            t++;
        end

        // Reset two cycles after the start pulse
        do_reset();
        node_d = 0;
        set_ops(16'h1234, 16'h4321);
        bus.REQ = 4'b0001;
        tick();
        check("rst_issue_st", bus.NODE_ST, 1);
        bus.REQ = '0;
        tick();
        tick();
        #2 RST = 1'b1;
        #1 check("rst_async", obs(), 0);
        tick();
        check("rst_hold", {bus.DONE, bus.BUSY}, 0);
        RST     = 1'b0;
        node_d  = 2;
        bus.REQ = 4'b0010;
        tick();
        check("rst_after_gnt", bus.GNT, 4'b0010);
        bus.REQ = '0;
        t = 0;
        while (bus.DONE == '0 && t < 20) begin
            tick();
            t++;
        end
        check("rst_after_done", bus.DONE, 4'b0010);
        check("rst_after_res", bus.RES, 16'h5555);
        tick();

        // Randomized run against a per-transaction timeline model
        do_reset();
        m_ptr = 0; m_g = 0; m_s = 0; m_done = 0; m_free = 0; m_act = 1'b0;
        m_e = 1'b0; m_r = '0; m_res = '0; m_nin0 = '0; m_nin1 = '0;
        for (int c = 0; c < 1500; c++) begin
            eg = '0; ed = '0; ee = 1'b0; est = 1'b0; eb = 1'b0;
            if (m_act && c >= m_s) begin
                eg  = 4'(1 << m_g);
                eb  = 1'b1;
                est = (c == m_s);
                if (c == m_done) begin
                    ed    = eg;
                    ee    = m_e;
                    m_res = m_r;
                end
            end
            check("rand_cycle", obs(), {5'b0, eg, ed, ee, est, eb, m_res, m_nin0, m_nin1});
            if (m_act && c == m_done) begin
                m_act  = 1'b0;
                m_ptr  = (m_g + 1) % N_REQ;
                m_free = c + 1;
            end

            rq = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            bus.REQ = rq;
            scramble();
            if (!m_act && c >= m_free && rq != 0) begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (rq[(m_ptr + k) % N_REQ]) begin
                        m_g = (m_ptr + k) % N_REQ;
                        break;
                    end
                end
                m_act  = 1'b1;
                m_s    = c + 1;
                m_nin0 = op0[m_g];
                m_nin1 = op1[m_g];
                case ($urandom_range(0, 9))
                    0:       d = 0;
                    1:       d = TIMEOUT + 1;
                    2:       d = TIMEOUT + 2;
                    default: d = $urandom_range(1, 8);
                endcase
                node_d = d;
                if (d != 0 && d <= TIMEOUT + 1) begin
                    m_done = m_s + d + 1;
                    m_e    = 1'b0;
                    m_r    = W'(m_nin0 + m_nin1);
                end else begin
                    m_done = m_s + TIMEOUT + 2;
                    m_e    = 1'b1;
                    m_r    = '0;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/node_share_arbiter.md
Name: node_share_arbiter

Overview:
- Shares one two-operand compute node (ST/RD/RES handshake, W-bit operands IN0/IN1) among N_REQ requesters.
- Grants the node round-robin, latches and holds the winner's operands, pulses the node's start, waits for ready, captures the result and returns it with a one-cycle DONE to the winner.
- Sits between client logic and a single root/node instance.
- A watchdog aborts a hung node.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- W, 16, operand/result width
- TIMEOUT, 255, max WAIT cycles before abort (≥1)
- CW, 8, watchdog counter width; must hold TIMEOUT

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous active-high reset, also routed to the shared node
- REQ  in  N_REQ  per-requester request level
- IN0_BUS  in  N_REQ*W  operand 0, requester i at bits [i*W +: W]
- IN1_BUS  in  N_REQ*W  operand 1, same packing
- GNT  out  N_REQ  one-hot grant, held for the whole service
- DONE  out  N_REQ  one-cycle completion pulse to the served requester
- ERR  out  1  one-cycle pulse, coincident with DONE, on watchdog abort
- RES  out  W  registered result, valid when DONE pulses, held until next DONE
- BUSY  out  1  high in every state except IDLE
- NODE_ST  out  1  start pulse to node
- NODE_IN0  out  W  registered operand 0 to node
- NODE_IN1  out  W  registered operand 1 to node
- NODE_RD  in  1  node ready
- NODE_RES  in  W  node result

Behaviour:
- Reset (async, RST=1):
  - State IDLE; round-robin pointer 0.
  - GNT, DONE, ERR, RES, BUSY, NODE_ST, NODE_IN0, NODE_IN1 all 0; watchdog 0.
  - Reset mid-operation abandons the service with no DONE. The node is reset by the same RST.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any REQ bit is set, select the first set bit scanning ptr, ptr+1, …, wrapping at N_REQ.
  - Latch that requester's operands into NODE_IN0/NODE_IN1, set GNT one-hot, go to ISSUE.
  - No REQ: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - NODE_ST=1; clear watchdog; go to WAIT.
  - NODE_RD is ignored in this cycle.
- WAIT:
  - NODE_ST=0; watchdog increments each cycle.
  - NODE_RD=1: RES<=NODE_RES, go to RESP.
  - Else if watchdog==TIMEOUT: RES<=0, set abort flag, go to RESP.
  - If NODE_RD=1 and watchdog==TIMEOUT in the same cycle, RD wins: normal completion, no ERR.
- RESP (1 cycle):
  - DONE[g]=1 and ERR=abort flag; GNT cleared at the end of the cycle.
  - ptr <= (g+1) mod N_REQ; abort flag cleared; go to IDLE.
- Latency, REQ first seen in IDLE at cycle 0:
  - cycle 1: GNT and NODE_ST high.
  - NODE_RD first high in cycle k≥2: DONE and RES valid in cycle k+1.
  - IDLE again in cycle k+2.
  - Minimum REQ-to-DONE latency is 3 cycles.
- Operands: NODE_IN0/NODE_IN1 stay constant from ISSUE through RESP; later changes on IN*_BUS are ignored.
- REQ dropped while granted: service completes and DONE still pulses.
- REQ still high in the IDLE cycle after DONE counts as a new request. Fairness holds because ptr has moved past the requester.
- Node contract: RD low within one cycle after ST. RD is only sampled in WAIT.
- DONE is never asserted for more than one requester or for more than one cycle per service.

Test Plan:
- Single request: REQ=0001, IN0=0x0003, IN1=0x0005, node model returns 0x0008 with RD 4 cycles after ST → GNT=0001 one cycle after REQ, one NODE_ST pulse, DONE=0001 one cycle after RD, RES=0x0008, ERR=0.
- Round-robin: REQ=1111 held, each requester drops REQ after its DONE → grant order 0,1,2,3; ptr=0 afterwards; each DONE carries that requester's own result.
- Fairness under continuous load: REQ=0101 held permanently → grants alternate 0,2,0,2; requester 0 never served twice in a row.
- Watchdog: node never asserts RD, TIMEOUT=10 → DONE and ERR pulse together 12 cycles after ST, RES=0x0000, next request served normally.
- Reset mid-WAIT: assert RST two cycles after NODE_ST → all outputs 0 immediately (asynchronous), no DONE; after release REQ=0010 is served and ptr starts from 0.
- Operand stability: change IN0_BUS during WAIT → NODE_IN0 unchanged, RES reflects the latched operands.
